// File: rtl/dig_ota_array.sv
// dig_ota_array: multi-channel clocked digital OTA.
// Each channel synchronises a Vip/Vin pin pair and integrates the differential
// step in a saturating up/down accumulator over a frame of DEC samples. At the
// end of the frame it decides the channel output. An accumulator exactly at
// MID (common mode) holds the previous decision.
// Optional build macro: DIGOTA_HYST_EN adds a +/-HYST decision margin around MID.
module dig_ota_array #(
    parameter int unsigned CH    = 4,
    parameter int unsigned ACC_W = 6,
    parameter int unsigned DEC   = 8,
    parameter int unsigned HYST  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic [CH-1:0] vip,
    input  logic [CH-1:0] vin,
    output logic [CH-1:0] out,
    output logic          out_valid,
    output logic [CH-1:0] flip
);

    localparam int unsigned CntW   = (DEC > 1) ? $clog2(DEC) : 1;
    localparam int unsigned MidVal = 1 << (ACC_W - 1);

    localparam logic [ACC_W-1:0] Mid     = {1'b1, {(ACC_W - 1){1'b0}}};
    localparam logic [ACC_W-1:0] AccMax  = {ACC_W{1'b1}};
    localparam logic [ACC_W-1:0] AccZero = {ACC_W{1'b0}};
    localparam logic [CntW-1:0]  CntLast = CntW'(DEC - 1);

`ifdef DIGOTA_HYST_EN
    localparam logic [ACC_W-1:0] RiseTh = Mid + ACC_W'(HYST);
    localparam logic [ACC_W-1:0] FallTh = Mid - ACC_W'(HYST);
`endif

    // Reject configurations where a frame could saturate or the margin leaves the range.
    if (DEC < 1 || DEC >= MidVal || HYST >= MidVal) begin : gen_bad_param
        $error("dig_ota_array: DEC or HYST out of range for ACC_W");
    end

    // {vin, vip} packed together through both synchroniser stages.
    logic [2*CH-1:0]  meta_q;
    logic [2*CH-1:0]  sync_q;

    logic [ACC_W-1:0] acc_q [CH];
    logic [ACC_W-1:0] acc_d [CH];
    logic [ACC_W-1:0] acc_nxt [CH];
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [CH-1:0]    out_q, out_d;
    logic [CH-1:0]    flip_q, flip_d;
    logic             valid_q, valid_d;
    logic [CH-1:0]    decision;
    logic             frame_end;

    assign frame_end = ena && (cnt_q == CntLast);

    // Per-channel saturating step and the frame-end decision on the stepped value.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            acc_nxt[i]  = acc_q[i];
            decision[i] = out_q[i];
            if (sync_q[i] && !sync_q[CH+i]) begin
                if (acc_q[i] != AccMax) acc_nxt[i] = acc_q[i] + ACC_W'(1);
            end else if (!sync_q[i] && sync_q[CH+i]) begin
                if (acc_q[i] != AccZero) acc_nxt[i] = acc_q[i] - ACC_W'(1);
            end
`ifdef DIGOTA_HYST_EN
            if (acc_nxt[i] >= RiseTh) begin
                decision[i] = 1'b1;
            end else if (acc_nxt[i] <= FallTh) begin
                decision[i] = 1'b0;
            end
`else
            if (acc_nxt[i] > Mid) begin
                decision[i] = 1'b1;
            end else if (acc_nxt[i] < Mid) begin
                decision[i] = 1'b0;
            end
`endif
        end
    end

    // Frame sequencing: accumulate while enabled, publish and restart at frame end.
    always_comb begin
        cnt_d   = cnt_q;
        out_d   = out_q;
        flip_d  = flip_q;
        valid_d = 1'b0;
        for (int i = 0; i < CH; i++) begin
            acc_d[i] = acc_q[i];
        end
        if (frame_end) begin
            out_d   = decision;
            flip_d  = decision ^ out_q;
            valid_d = 1'b1;
            cnt_d   = '0;
            for (int i = 0; i < CH; i++) begin
                acc_d[i] = Mid;
            end
        end else if (ena) begin
            flip_d = '0;
            cnt_d  = cnt_q + CntW'(1);
            for (int i = 0; i < CH; i++) begin
                acc_d[i] = acc_nxt[i];
            end
        end
    end

    // State registers; the synchroniser runs regardless of ena.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q  <= '0;
            sync_q  <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            flip_q  <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                acc_q[i] <= Mid;
            end
        end else begin
            meta_q  <= {vin, vip};
            sync_q  <= meta_q;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            flip_q  <= flip_d;
            valid_q <= valid_d;
            for (int i = 0; i < CH; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign out       = out_q;
    assign flip      = flip_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_dig_ota_array.sv
// Directed bench for dig_ota_array (CH=4, ACC_W=6, DEC=8, HYST=4).
module tb_dig_ota_array;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [3:0] vip;
    logic [3:0] vin;
    logic [3:0] out;
    logic       out_valid;
    logic [3:0] flip;

    int total;
    int bad;

    dig_ota_array #(
        .CH   (4),
        .ACC_W(6),
        .DEC  (8),
        .HYST (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .vip      (vip),
        .vin      (vin),
        .out      (out),
        .out_valid(out_valid),
        .flip     (flip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Preload the synchroniser with ena=0, then run one enabled frame where
    // cycle k of the frame sees nibble k of vps/vns.
    task automatic run_frame(input logic [31:0] vps, input logic [31:0] vns);
        ena = 1'b0;
        vip = vps[3:0];
        vin = vns[3:0];
        tick();
        vip = vps[7:4];
        vin = vns[7:4];
        tick();
        ena = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k < 6) begin
                vip = vps[4*(k+2) +: 4];
                vin = vns[4*(k+2) +: 4];
            end
            tick();
        end
    endtask

    task automatic test_reset;
        logic early;
        rst_n = 1'b0;
        ena   = 1'b1;
        vip   = 4'hF;
        vin   = 4'h0;
        repeat (3) tick();
        total++; if (out !== 4'h0) begin bad++; $display("FAIL reset_out got=%h exp=0", out); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (flip !== 4'h0) begin bad++; $display("FAIL reset_flip got=%h exp=0", flip); end
        rst_n = 1'b1;
        early = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            if (out_valid !== 1'b0) early = 1'b1;
        end
        total++; if (early !== 1'b0) begin bad++; $display("FAIL first_valid_early got=1 exp=0"); end
        tick();
        // Synchroniser was cleared, so only 6 of 8 samples count: acc_next=38.
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b exp=1", out_valid); end
        total++; if (out !== 4'hF) begin bad++; $display("FAIL first_out got=%h exp=f", out); end
        total++; if (flip !== 4'hF) begin bad++; $display("FAIL first_flip got=%h exp=f", flip); end
    endtask

    task automatic test_single_channel;
        run_frame(32'h0000_0000, 32'hFFFF_FFFF);
        total++; if (out !== 4'h0) begin bad++; $display("FAIL all_down_out got=%h exp=0", out); end
        total++; if (flip !== 4'hF) begin bad++; $display("FAIL all_down_flip got=%h exp=f", flip); end
        run_frame(32'h1111_1111, 32'h0000_0000);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ch0_up_valid got=%b exp=1", out_valid); end
        total++; if (out !== 4'h1) begin bad++; $display("FAIL ch0_up_out got=%h exp=1", out); end
        total++; if (flip !== 4'h1) begin bad++; $display("FAIL ch0_up_flip got=%h exp=1", flip); end
        run_frame(32'h1111_1111, 32'h0000_0000);
        total++; if (out !== 4'h1) begin bad++; $display("FAIL ch0_again_out got=%h exp=1", out); end
        total++; if (flip !== 4'h0) begin bad++; $display("FAIL ch0_again_flip got=%h exp=0", flip); end
    endtask

    task automatic test_common_mode;
        run_frame(32'h3333_3333, 32'h0000_0000);
        total++; if (out !== 4'h3) begin bad++; $display("FAIL ch1_up_out got=%h exp=3", out); end
        total++; if (flip !== 4'h2) begin bad++; $display("FAIL ch1_up_flip got=%h exp=2", flip); end
        run_frame(32'h2222_2222, 32'h2222_2222);
        total++; if (out !== 4'h3) begin bad++; $display("FAIL cm_hold_out got=%h exp=3", out); end
        total++; if (flip !== 4'h0) begin bad++; $display("FAIL cm_hold_flip got=%h exp=0", flip); end
        run_frame(32'h0000_0000, 32'h2222_2222);
        total++; if (out !== 4'h1) begin bad++; $display("FAIL ch1_down_out got=%h exp=1", out); end
        total++; if (flip !== 4'h2) begin bad++; $display("FAIL ch1_down_flip got=%h exp=2", flip); end
    endtask

    task automatic test_margin;
        logic [3:0] exp_out;
        logic [3:0] exp_flip;
        // ch2: 5 up then 3 down, acc_next=34.
        run_frame(32'h0004_4444, 32'h4440_0000);
`ifdef DIGOTA_HYST_EN
        exp_out  = 4'h1;
        exp_flip = 4'h0;
`else
        exp_out  = 4'h5;
        exp_flip = 4'h4;
`endif
        total++; if (out !== exp_out) begin bad++; $display("FAIL net2_out got=%h exp=%h", out, exp_out); end
        total++; if (flip !== exp_flip) begin bad++; $display("FAIL net2_flip got=%h exp=%h", flip, exp_flip); end
        run_frame(32'h0000_0000, 32'h4444_4444);
        total++; if (out !== 4'h1) begin bad++; $display("FAIL ch2_clear_out got=%h exp=1", out); end
        // ch2: 6 up then 2 down, acc_next=36.
        run_frame(32'h0044_4444, 32'h4400_0000);
        total++; if (out !== 4'h5) begin bad++; $display("FAIL net4_out got=%h exp=5", out); end
        total++; if (flip !== 4'h4) begin bad++; $display("FAIL net4_flip got=%h exp=4", flip); end
    endtask

    task automatic test_ena_pause;
        logic early;
        ena = 1'b0;
        vip = 4'hA;
        vin = 4'h5;
        tick();
        tick();
        ena = 1'b1;
        early = 1'b0;
        repeat (3) begin tick(); if (out_valid !== 1'b0) early = 1'b1; end
        ena = 1'b0;
        repeat (5) begin tick(); if (out_valid !== 1'b0) early = 1'b1; end
        ena = 1'b1;
        repeat (4) begin tick(); if (out_valid !== 1'b0) early = 1'b1; end
        total++; if (early !== 1'b0) begin bad++; $display("FAIL pause_early_valid got=1 exp=0"); end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pause_valid got=%b exp=1", out_valid); end
        total++; if (out !== 4'hA) begin bad++; $display("FAIL pause_out got=%h exp=a", out); end
        total++; if (flip !== 4'hF) begin bad++; $display("FAIL pause_flip got=%h exp=f", flip); end
    endtask

    task automatic test_mid_reset;
        logic early;
        ena = 1'b0;
        vip = 4'hF;
        vin = 4'h0;
        tick();
        tick();
        ena = 1'b1;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        total++; if (out !== 4'h0) begin bad++; $display("FAIL midrst_out got=%h exp=0", out); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
        rst_n = 1'b1;
        early = 1'b0;
        repeat (7) begin tick(); if (out_valid !== 1'b0) early = 1'b1; end
        total++; if (early !== 1'b0) begin bad++; $display("FAIL midrst_early_valid got=1 exp=0"); end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL midrst_valid8 got=%b exp=1", out_valid); end
        total++; if (out !== 4'hF) begin bad++; $display("FAIL midrst_new_out got=%h exp=f", out); end
        total++; if (flip !== 4'hF) begin bad++; $display("FAIL midrst_flip got=%h exp=f", flip); end
    endtask

    task automatic test_back_to_back;
        logic early;
        repeat (8) tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid1 got=%b exp=1", out_valid); end
        total++; if (flip !== 4'h0) begin bad++; $display("FAIL b2b_flip1 got=%h exp=0", flip); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_pulse got=%b exp=0", out_valid); end
        total++; if (flip !== 4'h0) begin bad++; $display("FAIL b2b_flip_clr got=%h exp=0", flip); end
        early = 1'b0;
        repeat (6) begin tick(); if (out_valid !== 1'b0) early = 1'b1; end
        total++; if (early !== 1'b0) begin bad++; $display("FAIL b2b_early_valid got=1 exp=0"); end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid2 got=%b exp=1", out_valid); end
        total++; if (out !== 4'hF) begin bad++; $display("FAIL b2b_out got=%h exp=f", out); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        ena   = 1'b1;
        vip   = 4'hF;
        vin   = 4'h0;
        test_reset();
        test_single_channel();
        test_common_mode();
        test_margin();
        test_ena_pause();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
